// File: rtl/reservation_station.sv
// Reservation station for ALU-class ops: buffers issued instructions, snoops the
// ALU/LSB result broadcasts for pending operands and dispatches one ready op per cycle.
module reservation_station #(
  parameter int unsigned RS_SIZE  = 16,
  parameter int unsigned ROB_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                issue,
  input  logic                rs_en,
  input  logic [ROB_BITS-1:0] rob_pos,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7,
  input  logic                rs1_rdy,
  input  logic [31:0]         rs1_val,
  input  logic [ROB_BITS-1:0] rs1_rob_pos,
  input  logic                rs2_rdy,
  input  logic [31:0]         rs2_val,
  input  logic [ROB_BITS-1:0] rs2_rob_pos,
  input  logic [31:0]         imm,
  input  logic [31:0]         pc,
  input  logic                alu_done,
  input  logic [31:0]         alu_res,
  input  logic [ROB_BITS-1:0] alu_res_rob_pos,
  input  logic                lsb_done,
  input  logic [31:0]         lsb_res,
  input  logic [ROB_BITS-1:0] lsb_res_rob_pos,
  output logic                rs_full,
  output logic                alu_en,
  output logic [6:0]          alu_opcode,
  output logic [2:0]          alu_funct3,
  output logic                alu_funct7,
  output logic [31:0]         alu_val1,
  output logic [31:0]         alu_val2,
  output logic [31:0]         alu_imm,
  output logic [31:0]         alu_pc,
  output logic [ROB_BITS-1:0] alu_rob_pos
);

  localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0]  busy_q, busy_d;
  logic [6:0]          op_q     [RS_SIZE];
  logic [6:0]          op_d     [RS_SIZE];
  logic [2:0]          f3_q     [RS_SIZE];
  logic [2:0]          f3_d     [RS_SIZE];
  logic                f7_q     [RS_SIZE];
  logic                f7_d     [RS_SIZE];
  logic                r1_rdy_q [RS_SIZE];
  logic                r1_rdy_d [RS_SIZE];
  logic [31:0]         r1_val_q [RS_SIZE];
  logic [31:0]         r1_val_d [RS_SIZE];
  logic [ROB_BITS-1:0] r1_tag_q [RS_SIZE];
  logic [ROB_BITS-1:0] r1_tag_d [RS_SIZE];
  logic                r2_rdy_q [RS_SIZE];
  logic                r2_rdy_d [RS_SIZE];
  logic [31:0]         r2_val_q [RS_SIZE];
  logic [31:0]         r2_val_d [RS_SIZE];
  logic [ROB_BITS-1:0] r2_tag_q [RS_SIZE];
  logic [ROB_BITS-1:0] r2_tag_d [RS_SIZE];
  logic [31:0]         imm_q    [RS_SIZE];
  logic [31:0]         imm_d    [RS_SIZE];
  logic [31:0]         pc_q     [RS_SIZE];
  logic [31:0]         pc_d     [RS_SIZE];
  logic [ROB_BITS-1:0] rob_q    [RS_SIZE];
  logic [ROB_BITS-1:0] rob_d    [RS_SIZE];

  logic                alu_en_q, alu_en_d;
  logic [6:0]          alu_op_q, alu_op_d;
  logic [2:0]          alu_f3_q, alu_f3_d;
  logic                alu_f7_q, alu_f7_d;
  logic [31:0]         alu_v1_q, alu_v1_d;
  logic [31:0]         alu_v2_q, alu_v2_d;
  logic [31:0]         alu_imm_q, alu_imm_d;
  logic [31:0]         alu_pc_q, alu_pc_d;
  logic [ROB_BITS-1:0] alu_rob_q, alu_rob_d;

  logic [IDX_W-1:0]    free_idx, disp_idx;
  logic                disp_found;
  logic [32:0]         wake1, wake2;

  // Returns {ready, value} for an operand after snooping both broadcasts; ALU wins a tag tie.
  function automatic logic [32:0] snoop(
    input logic op_rdy, input logic [31:0] op_val, input logic [ROB_BITS-1:0] op_tag,
    input logic a_done, input logic [31:0] a_res, input logic [ROB_BITS-1:0] a_tag,
    input logic l_done, input logic [31:0] l_res, input logic [ROB_BITS-1:0] l_tag);
    if (op_rdy)                        return {1'b1, op_val};
    else if (a_done && a_tag == op_tag) return {1'b1, a_res};
    else if (l_done && l_tag == op_tag) return {1'b1, l_res};
    else                               return {1'b0, op_val};
  endfunction

  assign rs_full = &busy_q;

  // Fixed-priority scans over registered state: lowest free slot, lowest ready entry.
  always_comb begin
    free_idx   = '0;
    disp_idx   = '0;
    disp_found = 1'b0;
    for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
      if (busy_q[i] && r1_rdy_q[i] && r2_rdy_q[i]) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    busy_d   = busy_q;
    op_d     = op_q;
    f3_d     = f3_q;
    f7_d     = f7_q;
    r1_rdy_d = r1_rdy_q;
    r1_val_d = r1_val_q;
    r1_tag_d = r1_tag_q;
    r2_rdy_d = r2_rdy_q;
    r2_val_d = r2_val_q;
    r2_tag_d = r2_tag_q;
    imm_d    = imm_q;
    pc_d     = pc_q;
    rob_d    = rob_q;
    alu_en_d  = 1'b0;
    alu_op_d  = alu_op_q;
    alu_f3_d  = alu_f3_q;
    alu_f7_d  = alu_f7_q;
    alu_v1_d  = alu_v1_q;
    alu_v2_d  = alu_v2_q;
    alu_imm_d = alu_imm_q;
    alu_pc_d  = alu_pc_q;
    alu_rob_d = alu_rob_q;
    wake1 = snoop(rs1_rdy, rs1_val, rs1_rob_pos, alu_done, alu_res, alu_res_rob_pos,
                  lsb_done, lsb_res, lsb_res_rob_pos);
    wake2 = snoop(rs2_rdy, rs2_val, rs2_rob_pos, alu_done, alu_res, alu_res_rob_pos,
                  lsb_done, lsb_res, lsb_res_rob_pos);

    if (rollback) begin
      busy_d = '0;
    end else if (rdy) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        if (busy_q[i]) begin
          {r1_rdy_d[i], r1_val_d[i]} = snoop(r1_rdy_q[i], r1_val_q[i], r1_tag_q[i],
              alu_done, alu_res, alu_res_rob_pos, lsb_done, lsb_res, lsb_res_rob_pos);
          {r2_rdy_d[i], r2_val_d[i]} = snoop(r2_rdy_q[i], r2_val_q[i], r2_tag_q[i],
              alu_done, alu_res, alu_res_rob_pos, lsb_done, lsb_res, lsb_res_rob_pos);
        end
      end
      if (disp_found) begin
        busy_d[disp_idx] = 1'b0;
        alu_en_d  = 1'b1;
        alu_op_d  = op_q[disp_idx];
        alu_f3_d  = f3_q[disp_idx];
        alu_f7_d  = f7_q[disp_idx];
        alu_v1_d  = r1_val_q[disp_idx];
        alu_v2_d  = r2_val_q[disp_idx];
        alu_imm_d = imm_q[disp_idx];
        alu_pc_d  = pc_q[disp_idx];
        alu_rob_d = rob_q[disp_idx];
      end
      // free_idx comes from registered busy bits, so a slot freed this edge is never reused here.
      if (issue && rs_en && !rs_full) begin
        busy_d[free_idx]   = 1'b1;
        op_d[free_idx]     = opcode;
        f3_d[free_idx]     = funct3;
        f7_d[free_idx]     = funct7;
        r1_rdy_d[free_idx] = wake1[32];
        r1_val_d[free_idx] = wake1[31:0];
        r1_tag_d[free_idx] = rs1_rob_pos;
        r2_rdy_d[free_idx] = wake2[32];
        r2_val_d[free_idx] = wake2[31:0];
        r2_tag_d[free_idx] = rs2_rob_pos;
        imm_d[free_idx]    = imm;
        pc_d[free_idx]     = pc;
        rob_d[free_idx]    = rob_pos;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      alu_en_q  <= 1'b0;
      alu_op_q  <= '0;
      alu_f3_q  <= '0;
      alu_f7_q  <= 1'b0;
      alu_v1_q  <= '0;
      alu_v2_q  <= '0;
      alu_imm_q <= '0;
      alu_pc_q  <= '0;
      alu_rob_q <= '0;
    end else begin
      busy_q    <= busy_d;
      op_q      <= op_d;
      f3_q      <= f3_d;
      f7_q      <= f7_d;
      r1_rdy_q  <= r1_rdy_d;
      r1_val_q  <= r1_val_d;
      r1_tag_q  <= r1_tag_d;
      r2_rdy_q  <= r2_rdy_d;
      r2_val_q  <= r2_val_d;
      r2_tag_q  <= r2_tag_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      rob_q     <= rob_d;
      alu_en_q  <= alu_en_d;
      alu_op_q  <= alu_op_d;
      alu_f3_q  <= alu_f3_d;
      alu_f7_q  <= alu_f7_d;
      alu_v1_q  <= alu_v1_d;
      alu_v2_q  <= alu_v2_d;
      alu_imm_q <= alu_imm_d;
      alu_pc_q  <= alu_pc_d;
      alu_rob_q <= alu_rob_d;
    end
  end

  assign alu_en      = alu_en_q;
  assign alu_opcode  = alu_op_q;
  assign alu_funct3  = alu_f3_q;
  assign alu_funct7  = alu_f7_q;
  assign alu_val1    = alu_v1_q;
  assign alu_val2    = alu_v2_q;
  assign alu_imm     = alu_imm_q;
  assign alu_pc      = alu_pc_q;
  assign alu_rob_pos = alu_rob_q;

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus randomized traffic, all
// checked every cycle against a slot-array reference model of the station.
module tb_reservation_station;

  localparam int unsigned N = 16;

  logic        clk;
  logic        rst, rdy, rollback, issue, rs_en;
  logic [3:0]  rob_pos, rs1_rob_pos, rs2_rob_pos, alu_res_rob_pos, lsb_res_rob_pos;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7, rs1_rdy, rs2_rdy, alu_done, lsb_done;
  logic [31:0] rs1_val, rs2_val, imm, pc, alu_res, lsb_res;
  logic        rs_full, alu_en, alu_funct7;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;

  reservation_station #(.RS_SIZE(16), .ROB_BITS(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .issue(issue), .rs_en(rs_en),
    .rob_pos(rob_pos), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_rdy(rs1_rdy), .rs1_val(rs1_val), .rs1_rob_pos(rs1_rob_pos),
    .rs2_rdy(rs2_rdy), .rs2_val(rs2_val), .rs2_rob_pos(rs2_rob_pos),
    .imm(imm), .pc(pc),
    .alu_done(alu_done), .alu_res(alu_res), .alu_res_rob_pos(alu_res_rob_pos),
    .lsb_done(lsb_done), .lsb_res(lsb_res), .lsb_res_rob_pos(lsb_res_rob_pos),
    .rs_full(rs_full), .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
    .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm),
    .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        r1;
    logic [31:0] v1;
    logic [3:0]  t1;
    logic        r2;
    logic [31:0] v2;
    logic [3:0]  t2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  rob;
  } slot_t;

  slot_t       m [N];
  logic        e_en, e_f7;
  logic [6:0]  e_op;
  logic [2:0]  e_f3;
  logic [31:0] e_v1, e_v2, e_imm, e_pc;
  logic [3:0]  e_rob;
  int          total, bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // An operand is usable if already ready, or if a broadcast this cycle names its producer.
  function automatic logic [32:0] resolve(input logic r, input logic [31:0] v, input logic [3:0] t);
    if (r) return {1'b1, v};
    if (alu_done && alu_res_rob_pos == t) return {1'b1, alu_res};
    if (lsb_done && lsb_res_rob_pos == t) return {1'b1, lsb_res};
    return {1'b0, v};
  endfunction

  function automatic logic model_full();
    for (int i = 0; i < int'(N); i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the reference model by one clock using the current inputs, then compare.
  task automatic step();
    slot_t nx [N];
    int    d, f;
    logic  full;
    full = model_full();
    if (rst) begin
      for (int i = 0; i < int'(N); i++) m[i].busy = 1'b0;
      e_en = 0; e_op = 0; e_f3 = 0; e_f7 = 0; e_v1 = 0; e_v2 = 0; e_imm = 0; e_pc = 0; e_rob = 0;
    end else if (rollback) begin
      for (int i = 0; i < int'(N); i++) m[i].busy = 1'b0;
      e_en = 1'b0;
    end else if (!rdy) begin
      e_en = 1'b0;
    end else begin
      if (issue && rs_en && full) chk("issue_while_full", 1, 0);
      d = -1; f = -1;
      for (int i = 0; i < int'(N); i++) begin
        if (d < 0 && m[i].busy && m[i].r1 && m[i].r2) d = i;
        if (f < 0 && !m[i].busy) f = i;
      end
      nx = m;
      for (int i = 0; i < int'(N); i++) if (m[i].busy) begin
        {nx[i].r1, nx[i].v1} = resolve(m[i].r1, m[i].v1, m[i].t1);
        {nx[i].r2, nx[i].v2} = resolve(m[i].r2, m[i].v2, m[i].t2);
      end
      e_en = (d >= 0);
      if (d >= 0) begin
        e_op = m[d].op; e_f3 = m[d].f3; e_f7 = m[d].f7; e_v1 = m[d].v1; e_v2 = m[d].v2;
        e_imm = m[d].imm; e_pc = m[d].pc; e_rob = m[d].rob;
        nx[d].busy = 1'b0;
      end
      if (issue && rs_en && !full) begin
        nx[f].busy = 1'b1; nx[f].op = opcode; nx[f].f3 = funct3; nx[f].f7 = funct7;
        {nx[f].r1, nx[f].v1} = resolve(rs1_rdy, rs1_val, rs1_rob_pos); nx[f].t1 = rs1_rob_pos;
        {nx[f].r2, nx[f].v2} = resolve(rs2_rdy, rs2_val, rs2_rob_pos); nx[f].t2 = rs2_rob_pos;
        nx[f].imm = imm; nx[f].pc = pc; nx[f].rob = rob_pos;
      end
      m = nx;
    end
    @(posedge clk);
    #1;
    chk("rs_full", 64'(rs_full), 64'(model_full()));
    chk("alu_en", 64'(alu_en), 64'(e_en));
    chk("alu_ctl", 64'({alu_opcode, alu_funct3, alu_funct7, alu_rob_pos}), 64'({e_op, e_f3, e_f7, e_rob}));
    chk("alu_val1", 64'(alu_val1), 64'(e_v1));
    chk("alu_val2", 64'(alu_val2), 64'(e_v2));
    chk("alu_imm_pc", {alu_imm, alu_pc}, {e_imm, e_pc});
  endtask

  task automatic idle();
    rst = 0; rdy = 1; rollback = 0; issue = 0; rs_en = 0; alu_done = 0; lsb_done = 0;
  endtask

  task automatic put(input logic [3:0] rob, input logic [6:0] op, input logic r1, input logic [31:0] v1,
                     input logic [3:0] t1, input logic r2, input logic [31:0] v2, input logic [3:0] t2,
                     input logic [31:0] im);
    issue = 1; rs_en = 1; rob_pos = rob; opcode = op; funct3 = 3'd0; funct7 = 1'b0;
    rs1_rdy = r1; rs1_val = v1; rs1_rob_pos = t1; rs2_rdy = r2; rs2_val = v2; rs2_rob_pos = t2;
    imm = im; pc = 32'h1000 + 32'(rob) * 4;
  endtask

  initial begin
    total = 0; bad = 0;
    for (int i = 0; i < int'(N); i++) m[i] = '0;
    e_en = 0; e_op = 0; e_f3 = 0; e_f7 = 0; e_v1 = 0; e_v2 = 0; e_imm = 0; e_pc = 0; e_rob = 0;
    idle();
    rob_pos = 0; opcode = 0; funct3 = 0; funct7 = 0; rs1_rdy = 0; rs1_val = 0; rs1_rob_pos = 0;
    rs2_rdy = 0; rs2_val = 0; rs2_rob_pos = 0; imm = 0; pc = 0;
    alu_res = 0; alu_res_rob_pos = 0; lsb_res = 0; lsb_res_rob_pos = 0;

    rst = 1; step(); step();
    chk("reset_full", 64'(rs_full), 0);
    chk("reset_en", 64'(alu_en), 0);
    idle();

    // ADDI with ready operand dispatches the cycle after issue.
    put(4'd2, 7'h13, 1, 32'd5, 4'd0, 1, 32'd0, 4'd0, 32'd3); step();
    idle(); step();
    chk("addi_en", 64'(alu_en), 1);
    chk("addi_v1", 64'(alu_val1), 5);
    chk("addi_imm", 64'(alu_imm), 3);
    chk("addi_rob", 64'(alu_rob_pos), 2);
    step();
    chk("addi_after", 64'(alu_en), 0);

    // ADD waiting on tag 7, woken by ALU broadcast two cycles later.
    put(4'd4, 7'h33, 0, 32'd0, 4'd7, 1, 32'd1, 4'd0, 32'd0); step();
    idle(); step();
    alu_done = 1; alu_res = 32'h10; alu_res_rob_pos = 4'd7; step();
    chk("wake_edge_en", 64'(alu_en), 0);
    idle(); step();
    chk("wake_en", 64'(alu_en), 1);
    chk("wake_v1", 64'(alu_val1), 32'h10);

    // Operand captured from an LSB broadcast in the issue cycle itself.
    put(4'd5, 7'h33, 1, 32'd9, 4'd0, 0, 32'd0, 4'd3, 32'd0);
    lsb_done = 1; lsb_res = 32'hAB; lsb_res_rob_pos = 4'd3; step();
    idle(); step();
    chk("lsb_issue_en", 64'(alu_en), 1);
    chk("lsb_issue_v2", 64'(alu_val2), 32'hAB);
    step();

    // Fill all slots waiting on tag 1, then drain them in index order.
    for (int i = 0; i < int'(N); i++) begin
      put(4'(i), 7'h33, 0, 32'd0, 4'd1, 1, 32'(i), 4'd0, 32'd0); step();
    end
    idle();
    chk("fill_full", 64'(rs_full), 1);
    alu_done = 1; alu_res = 32'h55; alu_res_rob_pos = 4'd1; step();
    chk("fill_full_wake", 64'(rs_full), 1);
    idle();
    for (int k = 0; k < int'(N); k++) begin
      step();
      chk("drain_en", 64'(alu_en), 1);
      chk("drain_rob", 64'(alu_rob_pos), 64'(k));
      chk("drain_full", 64'(rs_full), 0);
    end
    step();
    chk("drain_done", 64'(alu_en), 0);

    // Rollback with five pending entries and a concurrent ready issue.
    for (int i = 0; i < 5; i++) begin
      put(4'(i), 7'h63, 0, 32'd0, 4'd9, 1, 32'd0, 4'd0, 32'd0); step();
    end
    put(4'd6, 7'h13, 1, 32'd1, 4'd0, 1, 32'd1, 4'd0, 32'd0); rollback = 1; step();
    chk("rb_en", 64'(alu_en), 0);
    chk("rb_full", 64'(rs_full), 0);
    idle();
    alu_done = 1; alu_res = 32'h77; alu_res_rob_pos = 4'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rb_quiet", 64'(alu_en), 0);
    end
    idle();

    // Stall with rdy low: nothing dispatches until the first enabled edge.
    put(4'd8, 7'h37, 1, 32'd0, 4'd0, 1, 32'd0, 4'd0, 32'h1234_5000); step();
    idle(); rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_en", 64'(alu_en), 0);
    end
    rdy = 1; step();
    chk("stall_go", 64'(alu_en), 1);
    chk("stall_imm", 64'(alu_imm), 32'h1234_5000);
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 499) == 0);
      rollback = ($urandom_range(0, 99) == 0);
      rdy      = ($urandom_range(0, 7) != 0);
      issue    = ($urandom_range(0, 1) == 0);
      rs_en    = ($urandom_range(0, 3) != 0) && !model_full();
      rob_pos  = 4'($urandom); opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 1'($urandom);
      rs1_rdy  = 1'($urandom); rs1_val = $urandom; rs1_rob_pos = 4'($urandom_range(0, 7));
      rs2_rdy  = 1'($urandom); rs2_val = $urandom; rs2_rob_pos = 4'($urandom_range(0, 7));
      imm      = $urandom; pc = $urandom;
      alu_done = ($urandom_range(0, 2) == 0); alu_res = $urandom;
      alu_res_rob_pos = 4'($urandom_range(0, 7));
      lsb_done = ($urandom_range(0, 2) == 0); lsb_res = $urandom;
      lsb_res_rob_pos = ($urandom_range(0, 3) == 0) ? alu_res_rob_pos : 4'($urandom_range(0, 7));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
